// File: rtl/subleq_core_if.sv
// Memory bus between the SUBLEQ core (master) and its word-wide memory (slave).
// WORD_SIZE normally comes from defines.vh; it falls back to 8 when not predefined.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface subleq_core_if #(
    parameter int W = `WORD_SIZE
);
    logic         req;
    logic         load;
    logic         store;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         ack;
    logic [W-1:0] rdata;

    modport master (output req, load, store, addr, wdata, input ack, rdata);
    modport slave  (input req, load, store, addr, wdata, output ack, rdata);
endinterface

// File: rtl/subleq_core.sv
// SUBLEQ core: each instruction is six bus transfers (3 fetches, 2 operand reads, 1 write).
// Optional macro SUBLEQ_HALT_EN: a taken branch to all-ones parks the core in HALT until reset.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_core #(
    parameter logic [`WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  areset,
    subleq_core_if.master         bus,
    output logic [`WORD_SIZE-1:0] pc,
    output logic                  halted
);
    localparam int W = `WORD_SIZE;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        WRITE_B,
        HALT
    } state_t;

    state_t       state_q;
    logic [W-1:0] pc_q;
    logic [W-1:0] ra_q, rb_q, rc_q;
    logic [W-1:0] opa_q, opb_q;
    logic [W-1:0] diff_d;
    logic [W-1:0] pc_d;
    logic         taken_d;
`ifdef SUBLEQ_HALT_EN
    logic         halted_q;
`endif

    // Operands are frozen during WRITE_B, so the store data stays stable across wait states.
    always_comb begin
        diff_d  = opb_q - opa_q;
        taken_d = (diff_d == '0) || diff_d[W-1];
        pc_d    = taken_d ? rc_q : pc_q + W'(3);
    end

    always_comb begin
        bus.req   = 1'b0;
        bus.load  = 1'b0;
        bus.store = 1'b0;
        bus.addr  = pc_q;
        bus.wdata = diff_d;
        case (state_q)
            FETCH_A: begin bus.req = 1'b1; bus.load = 1'b1; bus.addr = pc_q;         end
            FETCH_B: begin bus.req = 1'b1; bus.load = 1'b1; bus.addr = pc_q + W'(1); end
            FETCH_C: begin bus.req = 1'b1; bus.load = 1'b1; bus.addr = pc_q + W'(2); end
            READ_A:  begin bus.req = 1'b1; bus.load = 1'b1; bus.addr = ra_q;         end
            READ_B:  begin bus.req = 1'b1; bus.load = 1'b1; bus.addr = rb_q;         end
            WRITE_B: begin bus.req = 1'b1; bus.store = 1'b1; bus.addr = rb_q;        end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q  <= FETCH_A;
            pc_q     <= RESET_PC;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
`ifdef SUBLEQ_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_A: if (bus.ack) begin ra_q  <= bus.rdata; state_q <= FETCH_B; end
                FETCH_B: if (bus.ack) begin rb_q  <= bus.rdata; state_q <= FETCH_C; end
                FETCH_C: if (bus.ack) begin rc_q  <= bus.rdata; state_q <= READ_A;  end
                READ_A:  if (bus.ack) begin opa_q <= bus.rdata; state_q <= READ_B;  end
                READ_B:  if (bus.ack) begin opb_q <= bus.rdata; state_q <= WRITE_B; end
                WRITE_B: begin
                    if (bus.ack) begin
                        pc_q <= pc_d;
`ifdef SUBLEQ_HALT_EN
                        if (taken_d && (rc_q == '1)) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else
`endif
                        state_q <= FETCH_A;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH_A;
            endcase
        end
    end

    assign pc = pc_q;
`ifdef SUBLEQ_HALT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_subleq_core.sv
// Testbench for subleq_core: directed programs plus random programs checked
// against an array-based SUBLEQ interpreter.
`timescale 1ns/1ps

module tb_subleq_core;
    localparam int W = 8;
    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic [7:0] pc;
    logic       halted;

    subleq_core_if #(.W(W)) bus ();

    subleq_core #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       ack_en = 1'b1;
    logic       stall_store = 1'b0;
    logic       rand_ack = 1'b0;
    logic       rnd_bit = 1'b1;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] fetch_q [$];

    assign bus.rdata = mem[bus.addr];
    assign bus.ack   = ack_en & ~(stall_store & bus.store) & (~rand_ack | rnd_bit);

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        if (!areset) begin
            mem <= img;
        end else if (bus.req && bus.ack) begin
            if (bus.store) begin
                mem[bus.addr] <= bus.wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= bus.addr;
                wr_data <= bus.wdata;
            end else if (bus.load) begin
                fetch_q.push_back(bus.addr);
            end
        end
    end

    // Bus protocol monitor
    logic        prot_bad = 1'b0;
    logic        ack_e = 1'b0, rst_e = 1'b0;
    logic        prev_ok = 1'b0;
    logic [19:0] prev_vec = '0;
    always @(posedge clk) begin ack_e = bus.ack; rst_e = areset; end
    always @(negedge clk) begin
        if (areset) begin
            if (bus.load && bus.store) prot_bad = 1'b1;
            if (!bus.req && (bus.load || bus.store)) prot_bad = 1'b1;
            if (prev_ok && rst_e && prev_vec[19] && !ack_e &&
                prev_vec !== {bus.req, bus.load, bus.store, bus.addr, bus.wdata, 1'b0})
                prot_bad = 1'b1;
        end
        prev_vec = {bus.req, bus.load, bus.store, bus.addr, bus.wdata, 1'b0};
        prev_ok  = areset && rst_e;
    end

    // Reference interpreter
    logic [7:0] rm [256];
    logic [7:0] ref_pc;

    task automatic clear_img();
        for (int unsigned i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 areset = 1'b0;
        repeat (2) @(negedge clk);
        rm = img;
        ref_pc = RST_PC;
        #1 areset = 1'b1;
    endtask

    task automatic step_check(input string tag, output int cyc, output bit halt_exp);
        logic [7:0] pa, pb, pcc, a_ad, b_ad, c, diff, nxt;
        int start;
        bit taken;
        pa = ref_pc; pb = ref_pc + 8'd1; pcc = ref_pc + 8'd2;
        a_ad = rm[pa]; b_ad = rm[pb]; c = rm[pcc];
        diff = rm[b_ad] - rm[a_ad];
        rm[b_ad] = diff;
        taken = ($signed(diff) <= 0);
        nxt = taken ? c : ref_pc + 8'd3;
`ifdef SUBLEQ_HALT_EN
        halt_exp = taken && (c == 8'hFF);
`else
        halt_exp = 1'b0;
`endif
        start = wr_cnt;
        cyc = 0;
        while (wr_cnt == start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (wr_cnt == start) begin
            errors++;
            $display("FAIL %s timeout: no write after %0d cycles (required 1 write)", tag, cyc);
        end
        checks++;
        if (wr_addr !== b_ad || wr_data !== diff) begin
            errors++;
            $display("FAIL %s write: got addr=%h data=%h required addr=%h data=%h",
                     tag, wr_addr, wr_data, b_ad, diff);
        end
        checks++;
        if (halt_exp) begin
            if (halted !== 1'b1 || bus.req !== 1'b0) begin
                errors++;
                $display("FAIL %s halt: got halted=%b req=%b required halted=1 req=0", tag, halted, bus.req);
            end
        end else if (pc !== nxt || halted !== 1'b0) begin
            errors++;
            $display("FAIL %s pc: got pc=%h halted=%b required pc=%h halted=0", tag, pc, halted, nxt);
        end
        ref_pc = nxt;
    endtask

    task automatic test_reset();
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h00; img[7] = 8'h03; img[8] = 8'h05;
        @(negedge clk); #1 areset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== RST_PC || bus.req !== 1'b1 || bus.load !== 1'b1 || bus.store !== 1'b0 ||
            bus.addr !== RST_PC || bus.wdata !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h req=%b load=%b store=%b addr=%h wdata=%h halted=%b required pc=%h req=1 load=1 store=0 addr=%h wdata=00 halted=0",
                     pc, bus.req, bus.load, bus.store, bus.addr, bus.wdata, halted, RST_PC, RST_PC);
        end
        rm = img;
        ref_pc = RST_PC;
        #1 areset = 1'b1;
    endtask

    task automatic test_basic();
        int cyc; bit h;
        step_check("basic", cyc, h);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL basic_cycles: got %0d required 6", cyc);
        end
        checks++;
        if (mem[8] !== 8'h02 || pc !== 8'h03) begin
            errors++;
            $display("FAIL basic_result: got mem8=%h pc=%h required mem8=02 pc=03", mem[8], pc);
        end
    endtask

    task automatic test_branch_zero();
        int cyc; bit h;
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h20; img[7] = 8'h05; img[8] = 8'h05;
        do_reset();
        step_check("branch_zero", cyc, h);
        clear_img();
        img[0] = 8'h09; img[1] = 8'h09; img[2] = 8'h40; img[9] = 8'h33;
        do_reset();
        step_check("a_eq_b", cyc, h);
    endtask

    task automatic test_sign_boundary();
        int cyc; bit h;
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h20; img[7] = 8'h01; img[8] = 8'h80;
        do_reset();
        step_check("diff_7f", cyc, h);
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h30; img[7] = 8'h01; img[8] = 8'h81;
        do_reset();
        img[0] = 8'h07;
        step_check("diff_80_prep", cyc, h);
    endtask

    task automatic test_wrap();
        int cyc; bit h;
        int n0;
        clear_img();
        img[0] = 8'h09; img[1] = 8'h09; img[2] = 8'hFE;
        img[8'hFE] = 8'h10; img[8'hFF] = 8'h11; img[8'h10] = 8'h01; img[8'h11] = 8'h05;
        do_reset();
        step_check("wrap_jump", cyc, h);
        n0 = fetch_q.size();
        step_check("wrap_exec", cyc, h);
        checks++;
        if (fetch_q.size() < n0 + 3 || fetch_q[n0] !== 8'hFE || fetch_q[n0+1] !== 8'hFF ||
            fetch_q[n0+2] !== 8'h00 || pc !== 8'h01) begin
            errors++;
            $display("FAIL wrap_fetch: got fetch=%h %h %h pc=%h required fe ff 00 pc=01",
                     fetch_q[n0], fetch_q[n0+1], fetch_q[n0+2], pc);
        end
    endtask

    task automatic test_wait_write();
        logic [7:0] ca, cw;
        int start, cyc;
        bit bad;
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h00; img[7] = 8'h03; img[8] = 8'h05;
        stall_store = 1'b1;
        do_reset();
        cyc = 0;
        while (!bus.store && cyc < 50) begin @(negedge clk); cyc++; end
        ca = bus.addr; cw = bus.wdata; start = wr_cnt; bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.store !== 1'b1 || bus.addr !== ca || bus.wdata !== cw) bad = 1'b1;
        end
        checks++;
        if (bad || ca !== 8'h08 || cw !== 8'h02) begin
            errors++;
            $display("FAIL wait_stable: got addr=%h wdata=%h unstable=%b required addr=08 wdata=02 stable", ca, cw, bad);
        end
        checks++;
        if (wr_cnt !== start) begin
            errors++;
            $display("FAIL wait_nowrite: got %0d writes required 0", wr_cnt - start);
        end
        stall_store = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt !== start + 1 || mem[8] !== 8'h02) begin
            errors++;
            $display("FAIL wait_onewrite: got %0d writes mem8=%h required 1 write mem8=02", wr_cnt - start, mem[8]);
        end
    endtask

    task automatic test_reset_mid();
        int start, cyc;
        clear_img();
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h00; img[7] = 8'h03; img[8] = 8'h05;
        stall_store = 1'b1;
        do_reset();
        cyc = 0;
        while (!bus.store && cyc < 50) begin @(negedge clk); cyc++; end
        start = wr_cnt;
        #1 areset = 1'b0;
        stall_store = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt !== start || pc !== RST_PC || bus.store !== 1'b0 || bus.addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_mid: got writes=%0d pc=%h store=%b addr=%h required writes=0 pc=%h store=0 addr=%h",
                     wr_cnt - start, pc, bus.store, bus.addr, RST_PC, RST_PC);
        end
        rm = img;
        ref_pc = RST_PC;
        #1 areset = 1'b1;
    endtask

    task automatic test_halt();
        int cyc; bit h, bad;
        clear_img();
        img[0] = 8'h09; img[1] = 8'h09; img[2] = 8'hFF; img[8'hFF] = 8'h0A; img[1] = 8'h09;
        do_reset();
        step_check("halt_branch", cyc, h);
`ifdef SUBLEQ_HALT_EN
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (halted !== 1'b1 || bus.req !== 1'b0 || bus.load !== 1'b0 || bus.store !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL halt_stay: got halted=%b req=%b required halted=1 req=0 throughout", halted, bus.req);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || bus.req !== 1'b1 || pc !== RST_PC) begin
            errors++;
            $display("FAIL halt_restart: got halted=%b req=%b pc=%h required halted=0 req=1 pc=%h",
                     halted, bus.req, pc, RST_PC);
        end
        step_check("halt_again", cyc, h);
`else
        bad = 1'b0;
        step_check("ff_jump_exec", cyc, h);
`endif
    endtask

    task automatic test_random();
        int cyc; bit h;
        rand_ack = 1'b1;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned i = 0; i < 256; i++) img[i] = 8'($urandom);
            do_reset();
            for (int unsigned s = 0; s < 25; s++) begin
                step_check($sformatf("rand%0d_%0d", r, s), cyc, h);
                if (h) break;
            end
        end
        rand_ack = 1'b0;
    endtask

    task automatic test_protocol();
        checks++;
        if (prot_bad !== 1'b0) begin
            errors++;
            $display("FAIL protocol: got violation=%b required 0", prot_bad);
        end
    endtask

    initial begin
        clear_img();
        test_reset();
        test_basic();
        test_branch_zero();
        test_sign_boundary();
        test_wrap();
        test_wait_write();
        test_reset_mid();
        test_halt();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
